uart_rx_frame_parser: RTL

Drains the 12-bit receive FIFO words ({BE, OE, PE, FE, data[7:0]}) produced by the UART receive wrapper. Assembles them into command frames (SOF, CMD, LEN, payload, XOR checksum) and presents each validated frame to the host-side logic on a valid/ready handshake. Frames with line errors, illegal length or a bad checksum are dropped and counted. While a frame is held unaccepted, the parser stops reading the FIFO, so back-pressure reaches the receiver through FIFO full.

---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_rx_frame_parser_if.sv | 34 +++
 rtl/uart_rx_frame_parser.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive frame parser: states, FIFO word layout, defaults.
package uart_frame_pkg;

    localparam int unsigned WORD_W     = 12;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned W_BE       = 11;
    localparam int unsigned W_OE       = 10;
    localparam int unsigned W_PE       = 9;
    localparam int unsigned W_FE       = 8;
    localparam int unsigned W_DATA_MSB = 7;
    localparam int unsigned W_DATA_LSB = 0;

    localparam logic [DATA_W-1:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

    // True when the receiver flagged any line error on this FIFO word.
    function automatic logic line_err(input logic [WORD_W-1:0] w);
        return w[W_BE] | w[W_OE] | w[W_PE] | w[W_FE];
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// FIFO-side and host-side signals of the frame parser, bundled for port connection.
interface uart_rx_frame_parser_if #(
    parameter int unsigned MAX_PAYLOAD = 16
);
    import uart_frame_pkg::*;

    logic [WORD_W-1:0]        fifo_rd_data;
    logic                     fifo_empty;
    logic                     fifo_rd_en;
    logic                     pkt_valid;
    logic                     pkt_ready;
    logic [DATA_W-1:0]        pkt_cmd;
    logic [4:0]               pkt_len;
    logic [MAX_PAYLOAD*8-1:0] pkt_payload;
    logic                     err_line;
    logic                     err_len;
    logic                     err_chk;
    logic [7:0]               err_cnt;

    // Parser side.
    modport master (
        input  fifo_rd_data, fifo_empty, pkt_ready,
        output fifo_rd_en, pkt_valid, pkt_cmd, pkt_len, pkt_payload,
               err_line, err_len, err_chk, err_cnt
    );

    // FIFO and host side.
    modport slave (
        output fifo_rd_data, fifo_empty, pkt_ready,
        input  fifo_rd_en, pkt_valid, pkt_cmd, pkt_len, pkt_payload,
               err_line, err_len, err_chk, err_cnt
    );

endinterface

// File: rtl/uart_rx_frame_parser.sv
// Assembles UART FIFO words into SOF/CMD/LEN/payload/CHK frames and hands valid frames to the host.
module uart_rx_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned       MAX_PAYLOAD = 16,
    parameter logic [DATA_W-1:0] SOF_BYTE    = SOF_DEFAULT
) (
    input  logic                   UART_clk,
    input  logic                   rst_n,
    uart_rx_frame_parser_if.master bus
);

    state_e                               r_state;
    state_e                               w_nxt;
    logic                                 r_rd_en;
    logic                                 r_cap;
    logic                                 r_pkt_valid;
    logic                                 r_err_line;
    logic                                 r_err_len;
    logic                                 r_err_chk;
    logic [7:0]                           r_err_cnt;
    logic [DATA_W-1:0]                    r_cmd;
    logic [DATA_W-1:0]                    r_xor;
    logic [4:0]                           r_len;
    logic [4:0]                           r_idx;
    logic [MAX_PAYLOAD-1:0][DATA_W-1:0]   r_payload;
    logic [DATA_W-1:0]                    w_data;
    logic                                 w_line;
    logic                                 w_err_line;
    logic                                 w_err_len;
    logic                                 w_err_chk;

    assign w_data = bus.fifo_rd_data[W_DATA_MSB:W_DATA_LSB];
    assign w_line = line_err(bus.fifo_rd_data);

    // State register.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HUNT;
        else        r_state <= w_nxt;
    end

    // Next state and error decisions; r_cap marks the cycle a requested word is on fifo_rd_data.
    always_comb begin
        w_nxt      = r_state;
        w_err_line = 1'b0;
        w_err_len  = 1'b0;
        w_err_chk  = 1'b0;
        if (r_state == ST_HOLD) begin
            if (r_pkt_valid && bus.pkt_ready) w_nxt = ST_HUNT;
        end else if (r_cap) begin
            if (w_line) begin
                w_err_line = 1'b1;
                w_nxt      = ST_HUNT;
            end else begin
                case (r_state)
                    ST_HUNT: if (w_data == SOF_BYTE) w_nxt = ST_CMD;
                    ST_CMD:  w_nxt = ST_LEN;
                    ST_LEN: begin
                        if (w_data > DATA_W'(MAX_PAYLOAD)) begin
                            w_err_len = 1'b1;
                            w_nxt     = ST_HUNT;
                        end else if (w_data == 8'd0) begin
                            w_nxt = ST_CHK;
                        end else begin
                            w_nxt = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: if (r_idx == r_len - 5'd1) w_nxt = ST_CHK;
                    ST_CHK: begin
                        if (w_data == r_xor) begin
                            w_nxt = ST_HOLD;
                        end else begin
                            w_err_chk = 1'b1;
                            w_nxt     = ST_HUNT;
                        end
                    end
                    default: w_nxt = ST_HUNT;
                endcase
            end
        end
    end

    // Read strobe (one read in flight, none while a frame is held), handshake and error outputs.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en     <= 1'b0;
            r_cap       <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_err_line  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_rd_en     <= !bus.fifo_empty && !r_rd_en && (w_nxt != ST_HOLD);
            r_cap       <= r_rd_en;
            r_pkt_valid <= (w_nxt == ST_HOLD);
            r_err_line  <= w_err_line;
            r_err_len   <= w_err_len;
            r_err_chk   <= w_err_chk;
            if ((w_err_line || w_err_len || w_err_chk) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Frame fields, payload buffer and running XOR, updated on each clean captured word.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_xor     <= '0;
            r_payload <= '0;
        end else if (r_cap && !w_line && (r_state != ST_HOLD)) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_data == SOF_BYTE) begin
                        r_xor     <= '0;
                        r_idx     <= '0;
                        r_payload <= '0;
                    end
                end
                ST_CMD: begin
                    r_cmd <= w_data;
                    r_xor <= r_xor ^ w_data;
                end
                ST_LEN: begin
                    r_len <= w_data[4:0];
                    r_idx <= '0;
                    r_xor <= r_xor ^ w_data;
                end
                ST_PAYLOAD: begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (r_idx == 5'(i)) r_payload[i] <= w_data;
                    end
                    r_idx <= r_idx + 5'd1;
                    r_xor <= r_xor ^ w_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rd_en  = r_rd_en;
    assign bus.pkt_valid   = r_pkt_valid;
    assign bus.pkt_cmd     = r_cmd;
    assign bus.pkt_len     = r_len;
    assign bus.pkt_payload = r_payload;
    assign bus.err_line    = r_err_line;
    assign bus.err_len     = r_err_len;
    assign bus.err_chk     = r_err_chk;
    assign bus.err_cnt     = r_err_cnt;

endmodule
